cpu_mem_arbiter: RTL and testbench
==================================

# cpu_mem_arbiter

Arbitrates a single-port main memory between the `cpu` instruction-fetch port and its load/store data port. It allows one memory transaction in flight at a time. Each transaction is sequenced through a four-state FSM with a response watchdog. The block sits between `cpu` and the memory model inside `top`, and is clocked by the same `clk`/`rst` pair.

## Interface
Parameters:
- `ADDR_W`, 32, address width (byte address)
- `DATA_W`, 32, data width
- `TIMEOUT`, 255, maximum cycles in WAIT before abort; 0 disables the watchdog

Ports:
- `clk` in 1 — system clock, rising edge
- `rst` in 1 — asynchronous, active-high reset
- `if_req` in 1 — fetch request; held with `if_addr` stable until `if_done`
- `if_addr` in ADDR_W — fetch address
- `if_done` out 1 — one-cycle completion pulse for the fetch port
- `if_rdata` out DATA_W — fetched word; valid while `if_done` is high
- `d_req` in 1 — data request; held with its fields stable until `d_done`
- `d_we` in 1 — 1 selects a store, 0 selects a load
- `d_addr` in ADDR_W — data address
- `d_wdata` in DATA_W — store data
- `d_wstrb` in DATA_W/8 — byte enables for stores
- `d_done` out 1 — one-cycle completion pulse for the data port
- `d_rdata` out DATA_W — load data; valid while `d_done` is high
- `err` out 1 — one-cycle pulse, concurrent with a done pulse, flags a watchdog abort
- `mem_req` out 1 — memory command valid
- `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb` out — registered command fields
- `mem_ready` in 1 — memory accepts the command in this cycle
- `mem_rvalid` in 1 — memory response, one pulse per command, including writes
- `mem_rdata` in DATA_W — read data, valid with `mem_rvalid`

## Operation
FSM states: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - If no request is pending, stay in IDLE.
  - Otherwise pick a winner, register the winner id and the command fields, and go to ISSUE.
- **ISSUE**
  - `mem_req`=1 with the registered fields.
  - On `mem_ready`, go to WAIT and clear the watchdog counter.
  - `mem_req` stays high until `mem_ready`, so the memory may stall indefinitely in ISSUE. The watchdog does not run in ISSUE.
- **WAIT**
  - `mem_req`=0 and the watchdog counter increments every cycle.
  - On `mem_rvalid`, capture `mem_rdata` into the winner's rdata register and go to DONE.
  - If `TIMEOUT`≠0 and the counter reaches `TIMEOUT` without `mem_rvalid`, set the error flag, force rdata to 0, and go to DONE.
- **DONE**
  - Pulse the winner's `*_done` for exactly one cycle; `err` is also high if the transaction aborted.
  - Then return to IDLE. Requests are not sampled in DONE, so a requester drops `req` during its done cycle.
- The loser of an arbitration keeps its `req` asserted and is served on a later pass through IDLE.
- `mem_rvalid` is ignored outside WAIT, including a late response after an abort.
- Reset, whether idle or mid-transaction:
  - FSM goes to IDLE.
  - `mem_req`, `*_done`, `err` = 0; all data and address registers = 0.
  - Last-winner register = fetch, so the data port wins first under round-robin.
  - The in-flight transaction is abandoned.
- The address is passed through unchanged. Alignment and byte-lane selection are the requester's responsibility.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Best case, with `mem_ready` and `mem_rvalid` both asserted on the first possible cycle:
  - req seen at edge 0 → `mem_req` high in cycle 1 (ISSUE)
  - `mem_ready` in cycle 1 → WAIT in cycle 2
  - `mem_rvalid` in cycle 2 → done pulse in cycle 3
  - Minimum latency is 3 cycles, and throughput is one transaction per 4 cycles.
- Abort: the done pulse occurs at cycle ISSUE-exit + `TIMEOUT` + 1. The counter is 8 bits wide, or wider if `TIMEOUT` needs it, and saturates.

## Configuration
- `ARB_RR_EN` defined: round-robin. With both requests pending, grant the port that did not win last; a lone request is always granted.
- `ARB_RR_EN` undefined: fixed priority, data port over fetch. The last-winner register is not implemented.

## Test plan
- **Lone fetch.** `if_req`, `if_addr`=0x0000_0010; memory asserts ready and rvalid immediately with rdata 0x0010_0093. Required: `mem_we`=0, `mem_addr`=0x10, `if_done` exactly 3 cycles after the request, `if_rdata`=0x0010_0093.
- **Store.** `d_req`, `d_we`=1, `d_addr`=0x100, `d_wdata`=0xDEAD_BEEF, `d_wstrb`=4'b0011. Required: those exact fields on the memory bus while `mem_req` is high, then `d_done`, with `if_done` staying 0.
- **Contention.** `if_req` and `d_req` asserted in the same cycle and held.
  - `ARB_RR_EN` undefined: order is data, fetch.
  - `ARB_RR_EN` defined, after reset: order is data, fetch, data, … on repeated collisions.
- **Stalls.** `mem_ready` low for 5 cycles, then `mem_rvalid` 4 cycles after acceptance. Required: `mem_req` held high for 6 cycles, no `err`, correct data delivered.
- **Timeout.** `TIMEOUT`=8 and `mem_rvalid` never arrives. Required: `d_done` and `err` pulse together 9 cycles after acceptance, `d_rdata`=0; a late `mem_rvalid` causes nothing.
- **Reset mid-transaction.** Assert `rst` asynchronously in WAIT. Required: `mem_req`, `*_done`, `err` go to 0 immediately with no clock edge; after release, a new request completes normally.

Source files
------------

// File: rtl/cpu_mem_arbiter.sv
// Single-outstanding arbiter of the CPU fetch and load/store ports onto one memory port.
// Define ARB_RR_EN for round-robin grant; otherwise the data port beats fetch.
module cpu_mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                if_req_i,
   input  logic [ADDR_W-1:0]   if_addr_i,
   output logic                if_done_o,
   output logic [DATA_W-1:0]   if_rdata_o,
   input  logic                d_req_i,
   input  logic                d_we_i,
   input  logic [ADDR_W-1:0]   d_addr_i,
   input  logic [DATA_W-1:0]   d_wdata_i,
   input  logic [DATA_W/8-1:0] d_wstrb_i,
   output logic                d_done_o,
   output logic [DATA_W-1:0]   d_rdata_o,
   output logic                err_o,
   output logic                mem_req_o,
   output logic                mem_we_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   output logic [DATA_W/8-1:0] mem_wstrb_o,
   input  logic                mem_ready_i,
   input  logic                mem_rvalid_i,
   input  logic [DATA_W-1:0]   mem_rdata_i
);
   localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
   localparam int SW    = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [SW-1:0]     wstrb;
   } cmd_t;

   state_t           state_q;
   cmd_t             cmd_q, cmd_d;
   logic             win_data_q, win_data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_hit;
   logic             mem_req_q, if_done_q, d_done_q, err_q;
   logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

   // win_data_q doubles as the last-winner record: it resets to fetch and holds until the next grant.
`ifdef ARB_RR_EN
   always_comb win_data_d = d_req_i && (!if_req_i || !win_data_q);
`else
   always_comb win_data_d = d_req_i;
`endif

   always_comb begin
      cmd_d = '0;
      if (win_data_d) begin
         cmd_d.we    = d_we_i;
         cmd_d.addr  = d_addr_i;
         cmd_d.wdata = d_wdata_i;
         cmd_d.wstrb = d_wstrb_i;
      end else begin
         cmd_d.addr  = if_addr_i;
      end
   end

   always_comb begin
      cnt_d       = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      timeout_hit = (TIMEOUT != 0) && (cnt_d == CNT_W'(TIMEOUT));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         cmd_q      <= '0;
         win_data_q <= 1'b0;
         cnt_q      <= '0;
         mem_req_q  <= 1'b0;
         if_done_q  <= 1'b0;
         d_done_q   <= 1'b0;
         err_q      <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         case (state_q)
            IDLE: if (if_req_i || d_req_i) begin
               win_data_q <= win_data_d;
               cmd_q      <= cmd_d;
               mem_req_q  <= 1'b1;
               state_q    <= ISSUE;
            end
            ISSUE: if (mem_ready_i) begin
               mem_req_q <= 1'b0;
               cnt_q     <= '0;
               state_q   <= WAIT;
            end
            WAIT: begin
               cnt_q <= cnt_d;
               // A real response wins over a watchdog expiry in the same cycle.
               if (mem_rvalid_i || timeout_hit) begin
                  if (win_data_q) d_rdata_q  <= mem_rvalid_i ? mem_rdata_i : '0;
                  else            if_rdata_q <= mem_rvalid_i ? mem_rdata_i : '0;
                  err_q     <= !mem_rvalid_i;
                  d_done_q  <= win_data_q;
                  if_done_q <= !win_data_q;
                  state_q   <= DONE;
               end
            end
            DONE: begin
               if_done_q <= 1'b0;
               d_done_q  <= 1'b0;
               err_q     <= 1'b0;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = cmd_q.we;
   assign mem_addr_o  = cmd_q.addr;
   assign mem_wdata_o = cmd_q.wdata;
   assign mem_wstrb_o = cmd_q.wstrb;
   assign if_done_o   = if_done_q;
   assign d_done_o    = d_done_q;
   assign err_o       = err_q;
   assign if_rdata_o  = if_rdata_q;
   assign d_rdata_o   = d_rdata_q;
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Scoreboard bench for cpu_mem_arbiter: expectations queued at stimulus time, popped on done pulses.
module tb_cpu_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int TO = 8;

   logic          clk = 1'b0, rst = 1'b1;
   logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [AW-1:0] if_addr = '0, d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic [SW-1:0] d_wstrb = '0;
   logic          if_done_o, d_done_o, err_o, mem_req_o, mem_we_o;
   logic [DW-1:0] if_rdata_o, d_rdata_o, mem_wdata_o;
   logic [AW-1:0] mem_addr_o;
   logic [SW-1:0] mem_wstrb_o;
   logic          mem_ready = 1'b0, mem_rvalid = 1'b0;
   logic [DW-1:0] mem_rdata = '0;

   cpu_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk_i(clk), .rst_i(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_done_o(if_done_o), .if_rdata_o(if_rdata_o),
      .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_wstrb_i(d_wstrb),
      .d_done_o(d_done_o), .d_rdata_o(d_rdata_o), .err_o(err_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
      .mem_ready_i(mem_ready), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic dp; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [SW-1:0] wstrb;
   } req_t;
   typedef struct {
      req_t r; logic [DW-1:0] rdata; logic err; int issue; int acc2done; int req2done;
   } exp_t;

   req_t f_list[$], d_list[$];
   exp_t exp_q[$];
   int   errors = 0, checks = 0, cyc = 0;
   int   rdy_lat = 0, rv_lat = 1, late_cyc = -1;
   int   acc_cyc = 0, issue_cnt = 0, f_req_cyc = 0, d_req_cyc = 0;
   int   m_stall = 0, m_wcnt = 0;
   logic m_pend = 1'b0;
   logic [AW-1:0] m_addr = '0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
      return {a[15:0], 16'h0093};
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   // Memory model: ready after rdy_lat stall cycles, response rv_lat cycles after acceptance (0 = never).
   initial begin
      forever begin
         @(posedge clk); #1;
         mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
         if (rst) begin
            m_pend = 1'b0; m_stall = 0;
         end else begin
            if (cyc == late_cyc) begin mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0; end
            if (m_pend) begin
               m_wcnt++;
               if (rv_lat != 0 && m_wcnt == rv_lat) begin
                  mem_rvalid = 1'b1; mem_rdata = memf(m_addr); m_pend = 1'b0;
               end
            end
            if (mem_req_o) begin
               if (m_stall < rdy_lat) m_stall++;
               else begin
                  mem_ready = 1'b1; m_stall = 0; m_pend = 1'b1; m_wcnt = 0; m_addr = mem_addr_o;
               end
            end
         end
      end
   end

   task automatic add(input logic dp, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input logic [SW-1:0] ws, input logic e, input int iss, input int a2d, input int r2d);
      req_t r; exp_t x;
      r.dp = dp; r.we = we; r.addr = a; r.wdata = wd; r.wstrb = ws;
      if (dp) d_list.push_back(r); else f_list.push_back(r);
      x.r = r; x.rdata = e ? '0 : memf(a); x.err = e;
      x.issue = iss; x.acc2done = a2d; x.req2done = r2d;
      exp_q.push_back(x);
   endtask

   task automatic run(input int budget);
      exp_t x; req_t r;
      issue_cnt = 0;
      for (int n = 0; n < budget && exp_q.size() != 0; n++) begin
         @(negedge clk);
         if (!if_req && f_list.size() != 0) begin
            r = f_list[0]; if_req = 1'b1; if_addr = r.addr; f_req_cyc = cyc;
         end
         if (!d_req && d_list.size() != 0) begin
            r = d_list[0]; d_req = 1'b1; d_we = r.we; d_addr = r.addr;
            d_wdata = r.wdata; d_wstrb = r.wstrb; d_req_cyc = cyc;
         end
         if (mem_req_o) issue_cnt++;
         if (mem_req_o && mem_ready) begin
            x = exp_q[0]; acc_cyc = cyc;
            chk("cmd_addr", mem_addr_o, x.r.addr);
            chk("cmd_we", mem_we_o, x.r.we);
            if (x.r.we) begin
               chk("cmd_wdata", mem_wdata_o, x.r.wdata);
               chk("cmd_wstrb", mem_wstrb_o, x.r.wstrb);
            end
            chk("req_cycles", issue_cnt, x.issue);
            issue_cnt = 0;
         end
         if (if_done_o || d_done_o) begin
            x = exp_q.pop_front();
            chk("done_port", {if_done_o, d_done_o}, x.r.dp ? 2'b01 : 2'b10);
            chk("rdata", x.r.dp ? d_rdata_o : if_rdata_o, x.rdata);
            chk("err", err_o, x.err);
            if (x.acc2done >= 0) chk("acc2done", cyc - acc_cyc, x.acc2done);
            if (x.req2done >= 0) chk("req2done", cyc - (x.r.dp ? d_req_cyc : f_req_cyc), x.req2done);
            if (x.r.dp) begin d_req = 1'b0; void'(d_list.pop_front()); end
            else        begin if_req = 1'b0; void'(f_list.pop_front()); end
         end else if (err_o) chk("err_alone", err_o, 1'b0);
      end
      if (exp_q.size() != 0) chk("budget", exp_q.size(), 0);
   endtask

   task automatic quiet(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk(tag, {mem_req_o, if_done_o, d_done_o, err_o}, 4'b0);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; if_req = 1'b0; d_req = 1'b0;
      exp_q.delete(); f_list.delete(); d_list.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL sim_timeout: got running want finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_outs", {mem_req_o, if_done_o, d_done_o, err_o, mem_we_o}, 5'b0);
      chk("rst_addr", mem_addr_o, 0);
      chk("rst_rdata", {if_rdata_o, d_rdata_o}, 0);
      rst = 1'b0;

      // lone fetch, best-case latency
      rdy_lat = 0; rv_lat = 1;
      add(1'b0, 1'b0, 32'h0000_0010, '0, '0, 1'b0, 1, 2, 3);
      run(40);
      // store, then a load on the data port
      add(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011, 1'b0, 1, 2, 3);
      run(40);
      add(1'b1, 1'b0, 32'h0000_0204, '0, '0, 1'b0, 1, 2, 3);
      run(40);
      // stalled memory
      rdy_lat = 5; rv_lat = 4;
      add(1'b0, 1'b0, 32'h0000_0040, '0, '0, 1'b0, 6, 5, -1);
      run(60);
      // watchdog abort, then a late response that must be ignored
      rdy_lat = 0; rv_lat = 0;
      add(1'b1, 1'b0, 32'h0000_0300, '0, '0, 1'b1, 1, TO + 1, -1);
      run(60);
      late_cyc = cyc + 2;
      quiet(6, "late_rvalid");
      chk("late_rdata", d_rdata_o, 0);

      // contention from reset
      do_reset();
      rdy_lat = 0; rv_lat = 1;
`ifdef ARB_RR_EN
      add(1'b1, 1'b1, 32'h0000_0800, 32'h0000_00A1, 4'hF, 1'b0, 1, 2, -1);
      add(1'b0, 1'b0, 32'h0000_0900, '0, '0, 1'b0, 1, 2, -1);
      add(1'b1, 1'b0, 32'h0000_0804, '0, '0, 1'b0, 1, 2, -1);
      add(1'b0, 1'b0, 32'h0000_0904, '0, '0, 1'b0, 1, 2, -1);
`else
      add(1'b1, 1'b1, 32'h0000_0800, 32'h0000_00A1, 4'hF, 1'b0, 1, 2, -1);
      add(1'b1, 1'b0, 32'h0000_0804, '0, '0, 1'b0, 1, 2, -1);
      add(1'b0, 1'b0, 32'h0000_0900, '0, '0, 1'b0, 1, 2, -1);
      add(1'b0, 1'b0, 32'h0000_0904, '0, '0, 1'b0, 1, 2, -1);
`endif
      run(100);

      // asynchronous reset while the command is stalled in ISSUE
      rdy_lat = 1000; rv_lat = 1;
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0500; d_wdata = 32'h1234_5678; d_wstrb = 4'hF;
      repeat (3) @(negedge clk);
      chk("pre_rst_req", mem_req_o, 1'b1);
      #2 rst = 1'b1;
      #1 chk("rst_issue", {mem_req_o, if_done_o, d_done_o, err_o}, 4'b0);
      chk("rst_issue_addr", mem_addr_o, 0);
      d_req = 1'b0;
      @(negedge clk); rst = 1'b0;

      // asynchronous reset while waiting for a response
      rdy_lat = 0; rv_lat = 0;
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0600;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1 chk("rst_wait", {mem_req_o, if_done_o, d_done_o, err_o}, 4'b0);
      chk("rst_wait_addr", mem_addr_o, 0);
      d_req = 1'b0;
      @(negedge clk); rst = 1'b0;

      rv_lat = 1;
      add(1'b0, 1'b0, 32'h0000_0700, '0, '0, 1'b0, 1, 2, 3);
      run(40);
      quiet(3, "post_idle");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
